// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: load-use stall sequencing, taken-branch
// squash, operand forwarding selects and saturating stall/flush counters.
module ex_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN,
        LDSTALL
    } state_t;

    // Remaining extra bubbles once the first hazard cycle has been spent.
    localparam logic [2:0] REM_INIT =
        (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
    localparam bit MULTI_STALL = (LOAD_STALL_CYCLES > 1);

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic br_taken;
    logic ld_hazard;
    logic stall_inc;
    logic flush_inc;

    assign br_taken  = exmem_branch & exmem_zero;
    assign ld_hazard = idex_memread & (idex_rt != 5'd0) &
                       ((idex_rt == id_rs) |
                        (id_uses_rt & (idex_rt == id_rt)));

    // Next-state and pipeline-control decode; reset forces a full bubble.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        stalled     = (state_q == LDSTALL);

        unique case (state_q)
            RUN: begin
                if (br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (ld_hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    if (MULTI_STALL) begin
                        state_d = LDSTALL;
                        rem_d   = REM_INIT;
                    end
                end
            end
            LDSTALL: begin
                if (br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                    state_d     = RUN;
                    rem_d       = 3'd0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    if (rem_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        rem_d = rem_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                rem_d   = 3'd0;
            end
        endcase

        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            stalled     = 1'b0;
        end
    end

    // Saturating counters; a clear beats a same-cycle increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst) begin
            if (exmem_regwrite && (exmem_rd != 5'd0) &&
                (exmem_rd == idex_rs)) begin
                fwd_a = 2'b10;
            end else if (memwb_regwrite && (memwb_rd != 5'd0) &&
                         (memwb_rd == idex_rs)) begin
                fwd_a = 2'b01;
            end
            if (exmem_regwrite && (exmem_rd != 5'd0) &&
                (exmem_rd == idex_rt)) begin
                fwd_b = 2'b10;
            end else if (memwb_regwrite && (memwb_rd != 5'd0) &&
                         (memwb_rd == idex_rt)) begin
                fwd_b = 2'b01;
            end
        end
    end

    // State, stall countdown and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            rem_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller sequencing the execute stage and its neighbouring pipeline latches. Detects load-use hazards against the ID/EX stage and stalls fetch/decode for a parameterised number of cycles. Squashes wrong-path instructions when a taken branch resolves out of the EX/MEM latch. Drives the EX operand forwarding selects and keeps saturating stall/flush performance counters.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 16, width of each performance counter.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of the instruction in IF/ID
- id_rt  in  5  rt field of the instruction in IF/ID
- id_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, beq)
- idex_memread  in  1  ID/EX instruction is a load
- idex_rs  in  5  rs field held in ID/EX
- idex_rt  in  5  rt field held in ID/EX
- exmem_regwrite  in  1  EX/MEM instruction writes the register file
- exmem_rd  in  5  EX/MEM destination (regdst mux result)
- exmem_branch  in  1  EX/MEM instruction is a branch (ctlm branch bit)
- exmem_zero  in  1  latched ALU zero
- memwb_regwrite  in  1  MEM/WB instruction writes the register file
- memwb_rd  in  5  MEM/WB destination
- cnt_clr  in  1  synchronous clear of both performance counters
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID latch enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_flush  out  1  zero ID/EX control fields on next edge (bubble)
- exmem_flush  out  1  zero EX/MEM control fields on next edge
- fwd_a  out  2  ALU operand A select: 00 rdata1, 10 EX/MEM result, 01 MEM/WB result
- fwd_b  out  2  same encoding, for the rdata2 path ahead of the alusrc mux
- stalled  out  1  FSM is in LDSTALL
- stall_cnt  out  CNT_W  cycles lost to load-use stalls
- flush_cnt  out  CNT_W  taken-branch squash events

## Operation
- br_taken = exmem_branch & exmem_zero.
- ld_hazard = idex_memread & (idex_rt != 0) & ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt))).
- FSM states: RUN, LDSTALL. A 3-bit down-counter rem is used in LDSTALL.
- RUN, no event: pc_write = ifid_write = 1; all flushes = 0.
- RUN with br_taken (highest priority):
  - ifid_flush = idex_flush = exmem_flush = 1; pc_write = ifid_write = 1.
  - Next state RUN; flush_cnt increments.
- RUN with ld_hazard and no br_taken:
  - pc_write = ifid_write = 0; idex_flush = 1; stall_cnt increments.
  - If LOAD_STALL_CYCLES > 1: next state LDSTALL, rem = LOAD_STALL_CYCLES - 2. Otherwise stay in RUN.
- LDSTALL, no br_taken:
  - pc_write = ifid_write = 0; idex_flush = 1; stall_cnt increments.
  - If rem == 0: next state RUN; else rem decrements.
- LDSTALL with br_taken: same outputs as RUN with br_taken; next state RUN, rem cleared. The squash wins over the stall.
- Forwarding (combinational, independent of FSM):
  - fwd_a = 10 if exmem_regwrite & exmem_rd != 0 & exmem_rd == idex_rs.
  - Else fwd_a = 01 if memwb_regwrite & memwb_rd != 0 & memwb_rd == idex_rs.
  - Else fwd_a = 00.
  - fwd_b: same rule, using idex_rt.
  - EX/MEM has priority over MEM/WB.
- Counters: saturate at all-ones (no wrap). cnt_clr clears both counters; clear wins over a simultaneous increment.

## Timing
- Output decode is combinational from state and inputs; state, rem and counters update on the rising clk edge.
- Load-use penalty is exactly LOAD_STALL_CYCLES cycles with pc_write = 0, measured from the first cycle ld_hazard is seen.
- Taken branch: squash asserted in the same cycle br_taken is high; three instructions are lost; one cycle of flush outputs.
- rst low (asynchronous):
  - state = RUN, rem = 0, stall_cnt = flush_cnt = 0.
  - Outputs forced: pc_write = 0, ifid_write = 0, ifid_flush = idex_flush = exmem_flush = 1, fwd_a = fwd_b = 00, stalled = 0.
  - Normal decode resumes on the first edge after rst rises.
- Reset asserted mid-stall aborts the stall immediately; no residual stall after release.

## Test plan
- lw $2 in ID/EX (idex_memread = 1, idex_rt = 2), add $3,$2,$4 in IF/ID (id_rs = 2), LOAD_STALL_CYCLES = 1 -> one cycle of pc_write = 0, idex_flush = 1; stall_cnt = 1; next cycle pc_write = 1.
- Same hazard with LOAD_STALL_CYCLES = 3 -> pc_write low for exactly 3 cycles; stalled high on cycles 2–3; stall_cnt = 3.
- exmem_branch = 1, exmem_zero = 1 on the second cycle of a 3-cycle stall -> that cycle all three flushes = 1 and pc_write = 1; FSM returns to RUN; flush_cnt = 1.
- idex_rt = 0 with idex_memread = 1, id_rs = 0 -> no stall; exmem_rd = memwb_rd = 5 = idex_rs, both regwrite = 1 -> fwd_a = 10; with exmem_regwrite = 0 -> fwd_a = 01.
- CNT_W = 4, drive 20 stall cycles -> stall_cnt holds 15; cnt_clr pulsed with a stall in the same cycle -> stall_cnt = 0.
- Assert rst low during LDSTALL -> outputs take reset values asynchronously; after release, no stall unless ld_hazard is present.
